// File: rtl/perf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : perf_pkg                                                         |
// | Brief   : Shared register map, mode encodings and CTRL field positions.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package perf_pkg;

  // Channel register offsets (addr[3:2])
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_LO     = 2'd1;
  localparam logic [1:0] OFF_HI     = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  // Global register offsets, valid when the channel field is all-ones
  localparam logic [1:0] OFF_GCTRL  = 2'd0;
  localparam logic [1:0] OFF_IRQ    = 2'd1;

  localparam logic [1:0] MODE_CLEAR = 2'd0;
  localparam logic [1:0] MODE_CYCLE = 2'd1;
  localparam logic [1:0] MODE_HOLD  = 2'd2;
  localparam logic [1:0] MODE_EVENT = 2'd3;

  localparam int CTRL_W             = 4;
  localparam int CTRL_MODE_LSB      = 0;
  localparam int CTRL_MODE_MSB      = 1;
  localparam int CTRL_IRQ_EN_BIT    = 2;
  localparam int CTRL_AUTO_STOP_BIT = 3;

  localparam int GCTRL_EN_BIT       = 0;
  localparam int GCTRL_CLR_BIT      = 1;

endpackage
`default_nettype wire

// File: rtl/perf_cntr_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : perf_cntr_chan                                                   |
// | Brief   : One counter channel: counter, CTRL, sticky ovf and HI shadow.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module perf_cntr_chan
  import perf_pkg::*;
#(
  parameter int CNT_WIDTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_all,
  input  logic              cnt_en,
  input  logic              event_in,
  input  logic              wr_ctrl,
  input  logic              wr_lo,
  input  logic              wr_hi,
  input  logic              wr_status,
  input  logic [31:0]       wdata,
  input  logic              rd_lo,
  output logic [CTRL_W-1:0] ctrl,
  output logic [31:0]       cnt_lo,
  output logic [31:0]       shadow_hi,
  output logic              ovf
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_hi_wr;
  logic [1:0]           r_mode;
  logic                 r_irq_en;
  logic                 r_auto_stop;
  logic                 r_ovf;
  logic                 w_wr_hi;
  logic                 w_inc;
  logic                 w_mode_acts;
  logic                 w_ovf_set;
  logic                 w_stop;

  assign w_inc = cnt_en && ((r_mode == MODE_CYCLE) ||
                            ((r_mode == MODE_EVENT) && event_in));

  // Overflow only counts when the mode increment actually owns this edge.
  assign w_mode_acts = !clear_all && !wr_lo && !w_wr_hi;
  assign w_ovf_set   = w_mode_acts && w_inc && (&r_cnt);
  assign w_stop      = w_ovf_set && r_auto_stop;

  generate
    if (CNT_WIDTH > 32) begin : g_hi
      logic [CNT_WIDTH-33:0] r_shadow;

      assign w_wr_hi     = wr_hi;
      assign w_cnt_hi_wr = {wdata[CNT_WIDTH-33:0], r_cnt[31:0]};
      assign shadow_hi   = 32'(r_shadow);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_shadow <= '0;
        end else if (rd_lo) begin
          r_shadow <= r_cnt[CNT_WIDTH-1:32];
        end
      end
    end else begin : g_no_hi
      logic w_unused_hi;

      assign w_wr_hi     = 1'b0;
      assign w_cnt_hi_wr = r_cnt;
      assign shadow_hi   = '0;
      assign w_unused_hi = ^{wr_hi, rd_lo};
    end
  endgenerate

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clear_all) begin
      w_cnt_nxt = '0;
    end else if (wr_lo) begin
      w_cnt_nxt[31:0] = wdata;
    end else if (w_wr_hi) begin
      w_cnt_nxt = w_cnt_hi_wr;
    end else if (r_mode == MODE_CLEAR) begin
      w_cnt_nxt = '0;
    end else if (w_inc && !w_stop) begin
      w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_mode      <= MODE_CLEAR;
      r_irq_en    <= 1'b0;
      r_auto_stop <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (wr_ctrl) begin
        r_mode      <= wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
        r_irq_en    <= wdata[CTRL_IRQ_EN_BIT];
        r_auto_stop <= wdata[CTRL_AUTO_STOP_BIT];
      end else if (w_stop) begin
        r_mode <= MODE_HOLD;
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (wr_status && wdata[0]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign ctrl   = {r_auto_stop, r_irq_en, r_mode};
  assign cnt_lo = r_cnt[31:0];
  assign ovf    = r_ovf;

endmodule
`default_nettype wire

// File: rtl/perf_cntr_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : perf_cntr_multi                                                  |
// | Brief   : Multi-channel perf counter: decode, GCTRL, read mux, irq.        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module perf_cntr_multi
  import perf_pkg::*;
#(
  parameter int NUM_CNTRS  = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  input  logic                  w_en_i,
  output logic [31:0]           rdata_o,
  input  logic [NUM_CNTRS-1:0]  event_i,
  output logic                  irq_o
);

  localparam int              CH_W      = ADDR_WIDTH - 4;
  localparam logic [CH_W-1:0] CH_GLOBAL = '1;

  logic [CH_W-1:0]      w_ch;
  logic [1:0]           w_off;
  logic                 w_glob;
  logic                 w_gctrl_wr;
  logic                 w_clear_all;
  logic                 w_unused_addr;
  logic [31:0]          w_rdata;
  logic [31:0]          r_rdata;
  logic                 r_en;
  logic                 r_irq;
  logic [CTRL_W-1:0]    w_ctrl   [NUM_CNTRS];
  logic [31:0]          w_cnt_lo [NUM_CNTRS];
  logic [31:0]          w_shadow [NUM_CNTRS];
  logic [NUM_CNTRS-1:0] w_ovf;
  logic [NUM_CNTRS-1:0] w_irq_en;
  logic [NUM_CNTRS-1:0] w_pend;

  assign w_ch          = addr_i[ADDR_WIDTH-1:4];
  assign w_off         = addr_i[3:2];
  assign w_glob        = (w_ch == CH_GLOBAL);
  assign w_unused_addr = ^addr_i[1:0];

  // clear_all is a pure strobe: it acts in the write cycle and is never stored.
  assign w_gctrl_wr  = w_en_i && w_glob && (w_off == OFF_GCTRL);
  assign w_clear_all = w_gctrl_wr && wdata_i[GCTRL_CLR_BIT];
  assign w_pend      = w_ovf & w_irq_en;

  generate
    for (genvar gi = 0; gi < NUM_CNTRS; gi++) begin : g_chan
      logic w_hit;

      assign w_hit = (w_ch == CH_W'(gi));

      perf_cntr_chan #(
        .CNT_WIDTH (CNT_WIDTH)
      ) u_chan (
        .clk       (clk_i),
        .rst_n     (rst_ni),
        .clear_all (w_clear_all),
        .cnt_en    (r_en),
        .event_in  (event_i[gi]),
        .wr_ctrl   (w_en_i && w_hit && (w_off == OFF_CTRL)),
        .wr_lo     (w_en_i && w_hit && (w_off == OFF_LO)),
        .wr_hi     (w_en_i && w_hit && (w_off == OFF_HI)),
        .wr_status (w_en_i && w_hit && (w_off == OFF_STATUS)),
        .wdata     (wdata_i),
        .rd_lo     (w_hit && (w_off == OFF_LO)),
        .ctrl      (w_ctrl[gi]),
        .cnt_lo    (w_cnt_lo[gi]),
        .shadow_hi (w_shadow[gi]),
        .ovf       (w_ovf[gi])
      );

      assign w_irq_en[gi] = w_ctrl[gi][CTRL_IRQ_EN_BIT];
    end
  endgenerate

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_CNTRS; i++) begin
      if (w_ch == CH_W'(i)) begin
        case (w_off)
          OFF_CTRL: w_rdata = 32'(w_ctrl[i]);
          OFF_LO:   w_rdata = w_cnt_lo[i];
          OFF_HI:   w_rdata = w_shadow[i];
          default:  w_rdata = 32'(w_ovf[i]);
        endcase
      end
    end
    if (w_glob) begin
      case (w_off)
        OFF_GCTRL: w_rdata = 32'(r_en);
        OFF_IRQ:   w_rdata = 32'(w_pend);
        default:   w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_en    <= 1'b1;
      r_irq   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_gctrl_wr) begin
        r_en <= wdata_i[GCTRL_EN_BIT];
      end
      r_irq   <= |w_pend;
      r_rdata <= w_rdata;
    end
  end

  assign rdata_o = r_rdata;
  assign irq_o   = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_perf_cntr_multi.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module  : tb_perf_cntr_multi                                               |
// | Brief   : Scoreboard bench for perf_cntr_multi with a behavioural model.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_perf_cntr_multi;

  localparam int NC = 4;
  localparam int CW = 64;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          w_en;
  logic [31:0]   rdata;
  logic [NC-1:0] ev_in;
  logic          irq;

  always #5 clk = ~clk;

  perf_cntr_multi #(
    .NUM_CNTRS  (NC),
    .CNT_WIDTH  (CW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .addr_i  (addr),
    .wdata_i (wdata),
    .w_en_i  (w_en),
    .rdata_o (rdata),
    .event_i (ev_in),
    .irq_o   (irq)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Behavioural reference model: register state as plain integers.
  longint unsigned m_cnt [NC];
  bit [1:0]        m_mode[NC];
  bit              m_ie  [NC];
  bit              m_as  [NC];
  bit              m_ovf [NC];
  bit [31:0]       m_sh  [NC];
  bit              m_en;

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = 0; m_mode[i] = 0; m_ie[i] = 0; m_as[i] = 0; m_ovf[i] = 0; m_sh[i] = 0;
    end
    m_en = 1;
  endfunction

  function automatic logic [31:0] model_pend();
    logic [31:0] p = 0;
    for (int i = 0; i < NC; i++) p[i] = m_ovf[i] & m_ie[i];
    return p;
  endfunction

  function automatic logic [31:0] model_rd(input logic [7:0] a);
    int ch  = int'(a[7:4]);
    int off = int'(a[3:2]);
    if (ch < NC) begin
      case (off)
        0:       return {28'd0, m_as[ch], m_ie[ch], m_mode[ch]};
        1:       return m_cnt[ch][31:0];
        2:       return m_sh[ch];
        default: return {31'd0, m_ovf[ch]};
      endcase
    end
    if (ch == 15 && off == 0) return {31'd0, m_en};
    if (ch == 15 && off == 1) return model_pend();
    return 0;
  endfunction

  function automatic void model_step(input logic [7:0] a, input logic [31:0] d,
                                     input bit we, input logic [NC-1:0] ev);
    int ch  = int'(a[7:4]);
    int off = int'(a[3:2]);
    bit clr = we && ch == 15 && off == 0 && d[1];
    for (int i = 0; i < NC; i++) begin
      bit wsel    = we && ch == i;
      bit inc     = m_en && (m_mode[i] == 1 || (m_mode[i] == 3 && ev[i]));
      bit ovf_set = 0;
      bit stop    = 0;
      if (ch == i && off == 1) m_sh[i] = m_cnt[i][63:32];
      if (clr)                         m_cnt[i] = 0;
      else if (wsel && off == 1)       m_cnt[i] = {m_cnt[i][63:32], d};
      else if (wsel && off == 2)       m_cnt[i] = {d, m_cnt[i][31:0]};
      else if (m_mode[i] == 0)         m_cnt[i] = 0;
      else if (inc) begin
        if (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) begin
          ovf_set = 1;
          if (m_as[i]) stop = 1;
          else         m_cnt[i] = 0;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
      if (ovf_set)                         m_ovf[i] = 1;
      else if (wsel && off == 3 && d[0])   m_ovf[i] = 0;
      if (wsel && off == 0) begin
        m_mode[i] = d[1:0]; m_ie[i] = d[2]; m_as[i] = d[3];
      end else if (stop) begin
        m_mode[i] = 2;
      end
    end
    if (we && ch == 15 && off == 0) m_en = d[0];
  endfunction

  // Scoreboard
  typedef struct {
    logic [31:0] rd;
    logic        irq;
    bit          fx;
    logic [31:0] fv;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   rd_req = 0;
  bit   rd_vld = 0;
  bit   mon_on = 0;

  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: got rdata 0x%08h with no expected entry", rdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.nm, "_model"}, rdata, mon_e.rd);
        chk({mon_e.nm, "_irq"}, {31'd0, irq}, {31'd0, mon_e.irq});
        if (mon_e.fx) chk({mon_e.nm, "_fixed"}, rdata, mon_e.fv);
      end
    end
  end

  task automatic cycle(input logic [7:0] a, input logic [31:0] d, input bit we,
                       input logic [NC-1:0] ev, input bit fx, input logic [31:0] fv,
                       input string nm);
    exp_t e;
    addr  = a;
    wdata = d;
    w_en  = we;
    ev_in = ev;
    e.rd  = model_rd(a);
    e.irq = |model_pend();
    e.fx  = fx;
    e.fv  = fv;
    e.nm  = nm;
    model_step(a, d, we, ev);
    rd_req = mon_on;
    if (mon_on) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cycle(a, d, 1'b1, '0, 1'b0, '0, "wr");
  endtask

  task automatic rd(input logic [7:0] a, input string nm);
    cycle(a, '0, 1'b0, '0, 1'b0, '0, nm);
  endtask

  task automatic rdx(input logic [7:0] a, input logic [31:0] v, input string nm);
    cycle(a, '0, 1'b0, '0, 1'b1, v, nm);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(8'h80, '0, 1'b0, '0, 1'b0, '0, "idle");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NC-1:0] ev;
    logic [7:0]    a;
    logic [31:0]   d;
    bit            we;
    int            r;

    rst_n = 1'b0; addr = '0; wdata = '0; w_en = 1'b0; ev_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rst_n  = 1'b1;
    mon_on = 1;
    rdx(8'h00, 32'd0, "rst_ctrl0");
    rdx(8'hF0, 32'd1, "rst_gctrl");
    rdx(8'h34, 32'd0, "rst_lo3");

    // Cycle count over a fixed window
    wr(8'h00, 32'd1);
    idle(99);
    wr(8'h00, 32'd2);
    rdx(8'h04, 32'd100, "t1_lo0");
    rdx(8'h08, 32'd0, "t1_hi0");

    // Coherent HI/LO across the 32-bit carry
    wr(8'h10, 32'd2);
    wr(8'h14, 32'hFFFF_FFFE);
    wr(8'h18, 32'd0);
    wr(8'h10, 32'd1);
    rdx(8'h14, 32'hFFFF_FFFE, "t2_lo_a");
    rdx(8'h18, 32'd0, "t2_hi_a");
    rdx(8'h14, 32'd0, "t2_lo_b");
    rdx(8'h18, 32'd1, "t2_hi_b");

    // Event counting on channel 2, channel 3 in cycle mode
    wr(8'h30, 32'd1);
    wr(8'h20, 32'd3);
    for (int k = 0; k < 14; k++) begin
      ev    = NC'($urandom);
      ev[2] = (k % 2 == 0);
      cycle(8'h24, '0, 1'b0, ev, 1'b0, '0, "t3_ev");
    end
    wr(8'h20, 32'd2);
    rdx(8'h24, 32'd7, "t3_lo2");
    rd(8'h34, "t3_lo3");

    // Wrap-around overflow with interrupt
    wr(8'h00, 32'd2);
    wr(8'h04, 32'hFFFF_FFFF);
    wr(8'h08, 32'hFFFF_FFFF);
    wr(8'h00, 32'd5);
    rdx(8'h0C, 32'd0, "t4_status_pre");
    rdx(8'h0C, 32'd1, "t4_status");
    chk("t4_irq_set", {31'd0, irq}, 32'd1);
    rdx(8'hF4, 32'd1, "t4_pend");
    rdx(8'h04, 32'd2, "t4_lo_wrapped");
    wr(8'h0C, 32'd1);
    idle(1);
    chk("t4_irq_clr", {31'd0, irq}, 32'd0);
    wr(8'h00, 32'd2);

    // Auto-stop and set-beats-clear on STATUS
    wr(8'h04, 32'hFFFF_FFFF);
    wr(8'h08, 32'hFFFF_FFFF);
    wr(8'h00, 32'd13);
    rdx(8'h04, 32'hFFFF_FFFF, "t5_lo_max");
    rdx(8'h00, 32'd14, "t5_ctrl_hold");
    rdx(8'h04, 32'hFFFF_FFFF, "t5_lo_held");
    rdx(8'h0C, 32'd1, "t5_ovf");
    wr(8'h0C, 32'd1);
    rdx(8'h0C, 32'd0, "t5_ovf_clr");
    wr(8'h00, 32'd13);
    wr(8'h0C, 32'd1);
    rdx(8'h0C, 32'd1, "t5_set_wins");
    wr(8'h0C, 32'd1);
    rdx(8'h0C, 32'd0, "t5_ovf_clr2");

    // Global freeze and clear
    wr(8'h00, 32'd1);
    wr(8'h20, 32'd1);
    wr(8'h30, 32'd1);
    wr(8'hF0, 32'd0);
    for (int k = 0; k < 10; k++) rd(8'((k % NC) * 16 + 4), "t6_frozen");
    wr(8'hF0, 32'd2);
    rdx(8'h04, 32'd0, "t6_lo0_clr");
    rdx(8'h14, 32'd0, "t6_lo1_clr");
    rdx(8'h24, 32'd0, "t6_lo2_clr");
    rdx(8'h34, 32'd0, "t6_lo3_clr");
    rdx(8'hF0, 32'd0, "t6_gctrl");
    wr(8'hF0, 32'd1);
    idle(5);

    // Asynchronous reset in the middle of counting with an interrupt pending
    wr(8'h00, 32'd2);
    wr(8'h04, 32'hFFFF_FFFF);
    wr(8'h08, 32'hFFFF_FFFF);
    wr(8'h00, 32'd5);
    idle(3);
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    mon_on = 0;
    rd(8'h14, "pre_rst");
    rd(8'h14, "pre_rst");
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_rdata", rdata, 32'd0);
    chk("rst_async_irq", {31'd0, irq}, 32'd0);
    model_reset();
    #7;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_on = 1;
    rdx(8'h04, 32'd0, "post_rst_lo0");
    rdx(8'h08, 32'd0, "post_rst_hi0");
    rdx(8'h0C, 32'd0, "post_rst_st0");
    rdx(8'h14, 32'd0, "post_rst_lo1");
    rdx(8'h00, 32'd0, "post_rst_ctrl0");
    rdx(8'hF0, 32'd1, "post_rst_gctrl");

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = {4'(r % NC), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      else if (r == 8) a = {4'hF, 2'($urandom_range(0, 3)), 2'b00};
      else             a = 8'($urandom);
      we = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      else                           d = $urandom;
      ev = NC'($urandom);
      cycle(a, d, we, ev, 1'b0, '0, "rand");
    end

    mon_on = 0;
    idle(2);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/perf_cntr_multi.md
Name: perf_cntr_multi

Overview:
Parametrised multi-channel performance counter. It is the successor to the single 64-bit mcycle counter on the dbus perf window (dbus_addr[30]).
- Provides NUM_CNTRS independent counters of CNT_WIDTH bits.
- Each counter can count cycles or external events, with optional auto-stop on overflow.
- Includes coherent HI/LO reads, sticky overflow flags and an interrupt output.
- The CPU reads it through the existing registered read mux with 1-cycle read latency.

Parameters:
NUM_CNTRS, 4, number of counter channels; must satisfy 1 <= NUM_CNTRS <= 2^(ADDR_WIDTH-4)-1.
CNT_WIDTH, 64, counter width; legal range 32..64.
ADDR_WIDTH, 8, byte-address bits decoded from dbus_addr.

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset, asynchronous, active-low
addr_i  in  ADDR_WIDTH  byte address within the perf window
wdata_i  in  32  write data
w_en_i  in  1  write strobe, single cycle
rdata_o  out  32  registered read data
event_i  in  NUM_CNTRS  per-channel event level, synchronous to clk_i
irq_o  out  1  registered OR of (ovf & irq_en) over all channels

Behaviour:
Address decode:
- ch = addr_i[ADDR_WIDTH-1:4]; off = addr_i[3:2].
- Channel registers (ch < NUM_CNTRS): off 0 CTRL, 1 LO, 2 HI, 3 STATUS.
- Global registers (ch = all-ones): off 0 GCTRL, 1 IRQ_PEND (read-only).
- Any other address reads 0; writes to it are ignored.

CTRL fields:
- [1:0] mode: 0 CLEAR, 1 CYCLE, 2 HOLD, 3 EVENT.
- [2] irq_en.
- [3] auto_stop.
- Reads return these fields; all other bits read 0.

Per-channel update (applied at the clock edge, in priority order):
1. Global clear strobe: counter <= 0.
2. Write to LO: counter[31:0] <= wdata_i.
3. Write to HI: counter[CNT_WIDTH-1:32] <= wdata_i truncated; ignored when CNT_WIDTH = 32.
4. Mode behaviour:
   - CLEAR: counter <= 0 every cycle.
   - HOLD: counter unchanged.
   - CYCLE: counter +1 when GCTRL.en = 1.
   - EVENT: counter +1 when GCTRL.en = 1 and event_i[ch] = 1.

Overflow:
- An increment from all-ones sets sticky ovf.
- auto_stop = 0: counter wraps to 0.
- auto_stop = 1: counter stays at all-ones and mode becomes HOLD in the same edge.

Write timing:
- A CTRL write takes effect next cycle. The increment in the write cycle uses the old mode.

STATUS:
- Bit 0 = ovf, write-1-to-clear.
- If a set and a W1C occur in the same cycle, the set wins.

Reads (1-cycle latency):
- A read of address A at cycle t presents data on rdata_o at t+1, sampled from register state at t, before the t-edge update.
- A LO read also latches counter[CNT_WIDTH-1:32] into shadow_hi[ch].
- A HI read returns shadow_hi[ch], never the live upper bits.
- When CNT_WIDTH = 32, HI reads 0.
- rdata_o updates every cycle from addr_i; no read strobe is needed.

GCTRL:
- [0] en, reset value 1.
- [1] clear_all strobe: self-clearing, reads 0, acts in the write cycle.

IRQ_PEND:
- bit i = ovf[i] & irq_en[i].
- irq_o = OR of IRQ_PEND, registered one cycle.

Reset (rst_ni low, asynchronous):
- All counters, shadows, ovf, CTRL (mode CLEAR) cleared.
- rdata_o = 0, irq_o = 0, GCTRL.en = 1.
- Reset mid-count discards all state immediately, with no clock needed.

Decomposition:
Shared package perf_pkg:
- Register offsets: OFF_CTRL, OFF_LO, OFF_HI, OFF_STATUS, OFF_GCTRL, OFF_IRQ.
- Mode encodings: MODE_CLEAR, MODE_CYCLE, MODE_HOLD, MODE_EVENT.
- CTRL bit positions.

Sub-module perf_cntr_chan:
- One channel: counter, CTRL, ovf, shadow_hi, update priority logic.
- Instantiated NUM_CNTRS times by a generate loop.
- The top holds the decode, GCTRL, read mux and irq register.

Test Plan:
1. Reset, then write CTRL0 = 1 and run 100 cycles, then set CTRL0 = 2 → a LO0 read returns 100 ± the fixed write-cycle offset (bench checks the exact value 100). HI0 reads 0.
2. CNT_WIDTH = 64: write LO1 = 0xFFFFFFFE, HI1 = 0, CTRL1 = 1; read LO1 across the 32-bit carry → HI1 returns the shadow consistent with LO (0 with LO = 0xFFFFFFFF, or 1 with LO = 0x00000000/1), never a torn pair.
3. CTRL2 = 3, event_i[2] pulsed high for 7 non-consecutive cycles and held low otherwise → LO2 = 7. Channel 3 in CYCLE mode is unaffected by event_i.
4. Preload counter0 to all-ones with CTRL0 = 0b0101 (CYCLE, irq_en) → next edge wraps to 0, STATUS0 = 1, irq_o = 1 one cycle later. Write STATUS0 = 1 → irq_o falls.
5. Same as 4 with auto_stop set → counter holds at all-ones and CTRL0 reads mode HOLD. W1C in the same cycle as an overflow set → ovf stays 1.
6. GCTRL = 0 freezes all counters for 10 cycles, then GCTRL = 2 clears all counters to 0. Assert rst_ni mid-count → rdata_o = 0 asynchronously, and all reads return 0 after release.
